// File: rtl/mem_req_queue_if.sv
// Producer and arbiter-port signals of one mem_req_queue instance.
// Directions in the signal names are from the queue's point of view.
interface mem_req_queue_if #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned PTR_WIDTH  = 2
);
  logic                  req_valid_i;
  logic                  req_ready_o;
  logic                  req_write_i;
  logic [ADDR_WIDTH-1:0] req_addr_i;
  logic [DATA_WIDTH-1:0] req_data_i;
  logic                  rsp_valid_o;
  logic [DATA_WIDTH-1:0] rsp_data_o;
  logic [PTR_WIDTH:0]    level_o;
  logic                  mem_rd_o;
  logic                  mem_wr_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_d4wt_o;
  logic                  mem_accept_i;
  logic [DATA_WIDTH-1:0] mem_d4rd_i;

  modport slave (
    input  req_valid_i, req_write_i, req_addr_i, req_data_i, mem_accept_i, mem_d4rd_i,
    output req_ready_o, rsp_valid_o, rsp_data_o, level_o, mem_rd_o, mem_wr_o, mem_addr_o,
           mem_d4wt_o
  );

  modport master (
    output req_valid_i, req_write_i, req_addr_i, req_data_i, mem_accept_i, mem_d4rd_i,
    input  req_ready_o, rsp_valid_o, rsp_data_o, level_o, mem_rd_o, mem_wr_o, mem_addr_o,
           mem_d4wt_o
  );
endinterface

// File: rtl/mem_req_queue.sv
// Request FIFO for one arbiter port: holds the head request until accepted and
// returns read data in order using the single-cycle memory read latency.
module mem_req_queue #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned PTR_WIDTH  = 2
) (
  input logic            clk,
  input logic            rst,
  mem_req_queue_if.slave bus
);

  localparam logic [PTR_WIDTH:0] LevelFull = (PTR_WIDTH + 1)'(DEPTH);

  logic                  wr_mem_q   [DEPTH];
  logic [ADDR_WIDTH-1:0] addr_mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem_q [DEPTH];

  logic [PTR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_WIDTH:0]    level_q, level_d;
  logic                  rd_pend_q, rd_pend_d;
  logic                  rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;

  logic empty, full, push, pop, head_write;

  assign empty      = (level_q == '0);
  assign full       = (level_q == LevelFull);
  assign head_write = wr_mem_q[rd_ptr_q];
  assign push       = bus.req_valid_i & ~full;
  assign pop        = ~empty & bus.mem_accept_i;

  assign bus.req_ready_o = ~full;
  assign bus.level_o     = level_q;
  assign bus.rsp_valid_o = rsp_valid_q;
  assign bus.rsp_data_o  = rsp_data_q;

  // Issue outputs depend on registered state only; mem_accept_i must not reach them.
  always_comb begin
    bus.mem_rd_o   = 1'b0;
    bus.mem_wr_o   = 1'b0;
    bus.mem_addr_o = '0;
    bus.mem_d4wt_o = '0;
    if (!empty) begin
      bus.mem_rd_o   = ~head_write;
      bus.mem_wr_o   = head_write;
      bus.mem_addr_o = addr_mem_q[rd_ptr_q];
      bus.mem_d4wt_o = data_mem_q[rd_ptr_q];
    end
  end

  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d    = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    rd_pend_d  = pop & ~head_write;
    // Memory data is valid the cycle after the accept, i.e. while rd_pend_q is set.
    rsp_data_d = rd_pend_q ? bus.mem_d4rd_i : rsp_data_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      rd_pend_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      rd_pend_q   <= rd_pend_d;
      rsp_valid_q <= rd_pend_q;
      rsp_data_q  <= rsp_data_d;
    end
  end

  // Entry storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      wr_mem_q[wr_ptr_q]   <= bus.req_write_i;
      addr_mem_q[wr_ptr_q] <= bus.req_addr_i;
      data_mem_q[wr_ptr_q] <= bus.req_data_i;
    end
  end

endmodule
